// File: rtl/sequenciador_de_instrucao.sv
// Multi-cycle instruction sequencer: fetches a 9-bit word over req/ready, then walks the PH1..PH3 phases.
// Optional retired-instruction counter is built only when INSTR_COUNTER_EN is defined.
module sequenciador_de_instrucao #(
    parameter int PC_WIDTH      = 8,
    parameter int FETCH_TIMEOUT = 15,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 run,
    input  logic                 step,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  mem_addr,
    output logic                 mem_req,
    input  logic                 mem_ready,
    input  logic [8:0]           mem_data,
    output logic [8:0]           iin,
    output logic [1:0]           counter,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] instr_count
);

    // Fetch handshake: mem_req rises on entry to FETCH and stays high until the cycle
    // in which mem_ready is sampled high (word accepted) or the timeout expires.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PH1,
        S_PH2,
        S_PH3,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [7:0] TMO_LIM = 8'(FETCH_TIMEOUT);
    localparam logic [2:0] OP_HLT  = 3'b011;

    state_t     state;
    logic [7:0] tmo_cnt;
    logic       step_q;
    logic       step_edge;

    assign step_edge = step & ~step_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            counter  <= 2'b00;
            iin      <= 9'h000;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            tmo_cnt  <= 8'd0;
            step_q   <= 1'b0;
        end else begin
            step_q <= step;
            case (state)
                S_IDLE: begin
                    if (run || step_edge) begin
                        state    <= S_FETCH;
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                        tmo_cnt  <= 8'd0;
                        busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        iin     <= mem_data;
                        mem_req <= 1'b0;
                        counter <= 2'b01;
                        state   <= S_PH1;
                    end else if (tmo_cnt + 8'd1 == TMO_LIM) begin
                        mem_req <= 1'b0;
                        fault   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_PH1: begin
                    // HLT stops here so the PC write in PH2/PH3 never happens.
                    if (iin[8:6] == OP_HLT) begin
                        counter <= 2'b00;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        counter <= 2'b10;
                        state   <= S_PH2;
                    end
                end
                S_PH2: begin
                    counter <= 2'b11;
                    state   <= S_PH3;
                end
                S_PH3: begin
                    counter <= 2'b00;
                    if (run) begin
                        state    <= S_FETCH;
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                        tmo_cnt  <= 8'd0;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                S_ERROR: begin
                    fault <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    counter <= 2'b00;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_COUNTER_EN
    logic [CNT_WIDTH-1:0] retired;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            retired <= '0;
        end else if (state == S_PH3 && retired != '1) begin
            retired <= retired + 1'b1;
        end
    end

    assign instr_count = retired;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_sequenciador_de_instrucao.sv
// Directed bench for sequenciador_de_instrucao with a req-counting memory model.
// Expected instr_count follows INSTR_COUNTER_EN the same way the design does.
module tb_sequenciador_de_instrucao;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  pc = 8'h00;
    logic        mem_ready = 1'b0;
    logic [8:0]  mem_data = 9'h000;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic [8:0]  iin;
    logic [1:0]  counter;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [15:0] instr_count;

    logic [8:0]  rom [256];
    logic [31:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    bit mem_en = 1'b1;
    int mem_delay = 1;
    int req_cnt = 0;
    int retired = 0;

    sequenciador_de_instrucao #(
        .PC_WIDTH(8), .FETCH_TIMEOUT(15), .CNT_WIDTH(16)
    ) dut (
        .clock(clock), .resetn(resetn), .run(run), .step(step), .pc(pc),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_data(mem_data), .iin(iin), .counter(counter), .busy(busy),
        .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef INSTR_COUNTER_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory answers after mem_delay cycles of continuous request; pc advances in PH3.
    task automatic mem_model();
        if (mem_req && mem_en) begin
            mem_ready = (req_cnt == mem_delay - 1);
            mem_data  = rom[mem_addr];
            req_cnt++;
        end else begin
            mem_ready = 1'b0;
            req_cnt   = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        if (counter == 2'b11) begin
            pc = pc + 8'd1;
            retired++;
        end
        mem_model();
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        run = 1'b0;
        step = 1'b0;
        repeat (2) cyc();
        check("rst_counter", 32'(counter), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_iin", 32'(iin), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_instr_count", 32'(instr_count), 32'd0);
        resetn = 1'b1;
        retired = 0;
    endtask

    initial begin
        int req_cyc;
        int busy_cyc;
        int ph2_seen;
        bit seen;
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;

        // single instruction in run mode, 1-cycle memory
        apply_reset();
        pc = 8'h00;
        rom[8'h00] = 9'b000_001_010;
        run = 1'b1;
        cyc();
        check("t1_fetch_req", 32'(mem_req), 32'd1);
        check("t1_fetch_cnt", 32'(counter), 32'd0);
        check("t1_fetch_busy", 32'(busy), 32'd1);
        check("t1_fetch_addr", 32'(mem_addr), 32'h00);
        run = 1'b0;
        cyc();
        check("t1_ph1_cnt", 32'(counter), 32'd1);
        check("t1_ph1_req", 32'(mem_req), 32'd0);
        check("t1_iin", 32'(iin), 32'h00A);
        cyc();
        check("t1_ph2_cnt", 32'(counter), 32'd2);
        cyc();
        check("t1_ph3_cnt", 32'(counter), 32'd3);
        cyc();
        check("t1_end_cnt", 32'(counter), 32'd0);
        check("t1_end_busy", 32'(busy), 32'd0);
        check("t1_instr_count", 32'(instr_count), exp_cnt(1));
        cyc();
        check("t1_idle_req", 32'(mem_req), 32'd0);

        // single step; a second edge while busy is dropped
        pc = 8'h05;
        rom[8'h05] = 9'h053;
        step = 1'b1;
        cyc();
        check("t2_addr", 32'(mem_addr), 32'h05);
        check("t2_req", 32'(mem_req), 32'd1);
        cyc();
        check("t2_iin", 32'(iin), 32'h053);
        check("t2_ph1_cnt", 32'(counter), 32'd1);
        step = 1'b0;
        cyc();
        step = 1'b1;
        cyc();
        cyc();
        check("t2_idle_busy", 32'(busy), 32'd0);
        repeat (3) cyc();
        check("t2_no_extra_busy", 32'(busy), 32'd0);
        check("t2_no_extra_req", 32'(mem_req), 32'd0);
        check("t2_retired", 32'(retired), 32'd2);
        check("t2_instr_count", 32'(instr_count), exp_cnt(2));
        step = 1'b0;
        cyc();

        // run and step edge together: one fetch only
        pc = 8'h06;
        rom[8'h06] = 9'h0A5;
        step = 1'b1;
        run = 1'b1;
        cyc();
        check("t2b_req", 32'(mem_req), 32'd1);
        run = 1'b0;
        repeat (7) cyc();
        check("t2b_busy", 32'(busy), 32'd0);
        check("t2b_retired", 32'(retired), 32'd3);
        check("t2b_iin", 32'(iin), 32'h0A5);
        step = 1'b0;

        // HLT as third word in run mode
        apply_reset();
        pc = 8'h10;
        rom[8'h10] = 9'h00A;
        rom[8'h11] = 9'h053;
        rom[8'h12] = 9'b011_000_000;
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 0, 0};
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check($sformatf("t3_cnt_%0d", i), 32'(counter), exp_q.pop_front());
        end
        check("t3_halted", 32'(halted), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_iin", 32'(iin), 32'h0C0);
        check("t3_addr", 32'(mem_addr), 32'h12);
        check("t3_retired", 32'(retired), 32'd2);
        check("t3_instr_count", 32'(instr_count), exp_cnt(2));
        run = 1'b0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        step = 1'b1;
        run = 1'b1;
        repeat (4) cyc();
        check("t3_still_halted", 32'(halted), 32'd1);
        check("t3_still_req", 32'(mem_req), 32'd0);
        check("t3_still_cnt", 32'(counter), 32'd0);
        check("t3_still_retired", 32'(retired), 32'd2);
        apply_reset();

        // fetch timeout
        mem_en = 1'b0;
        run = 1'b1;
        req_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (fault) break;
            if (mem_req) req_cyc++;
        end
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_req_cycles", 32'(req_cyc), 32'd15);
        check("t4_req_dropped", 32'(mem_req), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        repeat (5) cyc();
        check("t4_fault_sticky", 32'(fault), 32'd1);
        apply_reset();
        mem_en = 1'b1;

        // 3-cycle memory, 4 instructions, run dropped in PH2 of the 4th
        apply_reset();
        mem_delay = 3;
        pc = 8'h20;
        rom[8'h20] = 9'h011;
        rom[8'h21] = 9'h08B;
        rom[8'h22] = 9'h113;
        rom[8'h23] = 9'h1A4;
        run = 1'b1;
        busy_cyc = 0;
        req_cyc = 0;
        ph2_seen = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (!busy) break;
            busy_cyc++;
            if (mem_req) req_cyc++;
            if (counter == 2'b10) begin
                ph2_seen++;
                if (ph2_seen == 4) run = 1'b0;
            end
        end
        check("t5_busy_cycles", 32'(busy_cyc), 32'd24);
        check("t5_req_cycles", 32'(req_cyc), 32'd12);
        check("t5_retired", 32'(retired), 32'd4);
        check("t5_instr_count", 32'(instr_count), exp_cnt(4));
        check("t5_iin", 32'(iin), 32'h1A4);
        check("t5_addr", 32'(mem_addr), 32'h23);
        check("t5_cnt", 32'(counter), 32'd0);
        mem_delay = 1;

        // asynchronous reset in FETCH and in PH2
        apply_reset();
        mem_en = 1'b0;
        run = 1'b1;
        cyc();
        check("t6_fetch_req", 32'(mem_req), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t6_async_req", 32'(mem_req), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        run = 1'b0;
        apply_reset();
        mem_en = 1'b1;
        pc = 8'h30;
        rom[8'h30] = 9'h053;
        run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (counter == 2'b10) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_reached_ph2", 32'(seen), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t6_ph2_cnt", 32'(counter), 32'd0);
        check("t6_ph2_iin", 32'(iin), 32'd0);
        check("t6_ph2_addr", 32'(mem_addr), 32'd0);
        check("t6_ph2_busy", 32'(busy), 32'd0);
        check("t6_ph2_req", 32'(mem_req), 32'd0);
        check("t6_ph2_halted", 32'(halted), 32'd0);
        check("t6_ph2_fault", 32'(fault), 32'd0);
        check("t6_ph2_count", 32'(instr_count), 32'd0);
        run = 1'b0;
        cyc();
        resetn = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
